// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_pkg                                                                  |
// | Shared opcodes, funct3/funct7 constants, ALU codes and decoded-control   |
// | record used by the ID stage.                                             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,  ALU_SUB   = 5'd1,  ALU_LUI  = 5'd2,  ALU_AND  = 5'd3,
    ALU_XOR    = 5'd4,  ALU_OR    = 5'd5,  ALU_SLL  = 5'd6,  ALU_SRL  = 5'd7,
    ALU_SRA    = 5'd8,  ALU_SLT   = 5'd9,  ALU_SLTU = 5'd10, ALU_MUL  = 5'd11,
    ALU_MULH   = 5'd12, ALU_MULHSU = 5'd13, ALU_MULHU = 5'd14, ALU_DIV = 5'd15,
    ALU_DIVU   = 5'd16, ALU_REM   = 5'd17, ALU_REMU = 5'd18
  } alu_op_e;

  // Width-independent decoded control fields (the immediate travels separately)
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [4:0] alucode;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] funct3;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       jump;
    logic       jalr;
    logic       branch;
    logic       illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_core                                                              |
// | Purely combinational RV32I/RV64I (+ optional M) instruction decoder.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module decode_core
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output ctrl_t           ctrl_o,
  output logic            uses_rs1_o,
  output logic            uses_rs2_o
);

  // Shift amount is one bit wider on RV64; the bits above it act as funct6/7
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [11-SHW:0] w_shf_hi;
  logic            w_shf_base;
  logic            w_shf_alt;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

  assign w_opc      = instr_i[6:0];
  assign w_f3       = instr_i[14:12];
  assign w_f7       = instr_i[31:25];
  assign w_shf_hi   = instr_i[31:20+SHW];
  assign w_shf_base = (w_shf_hi == '0);
  assign w_shf_alt  = (w_shf_hi == {2'b01, {(10-SHW){1'b0}}});

  assign w_imm_i  = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign w_imm_b  = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_u  = {{(XLEN-31){instr_i[31]}}, instr_i[30:12], 12'b0};
  assign w_imm_j  = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign w_imm_sh = {{(XLEN-SHW){1'b0}}, instr_i[20 +: SHW]};

  // Decode every field from scratch each cycle; illegal encodings squash side effects
  always_comb begin
    imm_o           = '0;
    ctrl_o          = '0;
    ctrl_o.rs1      = instr_i[19:15];
    ctrl_o.rs2      = instr_i[24:20];
    ctrl_o.rd       = instr_i[11:7];
    ctrl_o.funct3   = w_f3;
    ctrl_o.alucode  = ALU_ADD;
    ctrl_o.alusrcb  = 2'd1;
    uses_rs1_o      = 1'b0;
    uses_rs2_o      = 1'b0;
    case (w_opc)
      OPC_LUI: begin
        imm_o = w_imm_u; ctrl_o.alucode = ALU_LUI; ctrl_o.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        imm_o = w_imm_u; ctrl_o.alusrca = 1'b1; ctrl_o.regwrite = 1'b1;
      end
      OPC_JAL: begin
        imm_o = w_imm_j; ctrl_o.alusrca = 1'b1; ctrl_o.alusrcb = 2'd2;
        ctrl_o.regwrite = 1'b1; ctrl_o.jump = 1'b1;
      end
      OPC_JALR: begin
        imm_o = w_imm_i; ctrl_o.alusrca = 1'b1; ctrl_o.alusrcb = 2'd2;
        ctrl_o.regwrite = 1'b1; ctrl_o.jump = 1'b1; ctrl_o.jalr = 1'b1;
        uses_rs1_o = 1'b1;
      end
      OPC_BRANCH: begin
        imm_o = w_imm_b; ctrl_o.alusrcb = 2'd0; ctrl_o.branch = 1'b1;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
        case (w_f3)
          F3_BLT, F3_BGE:   ctrl_o.alucode = ALU_SLT;
          F3_BLTU, F3_BGEU: ctrl_o.alucode = ALU_SLTU;
          default:          ctrl_o.alucode = ALU_SUB;
        endcase
      end
      OPC_LOAD: begin
        imm_o = w_imm_i; ctrl_o.regwrite = 1'b1; ctrl_o.memread = 1'b1;
        ctrl_o.memtoreg = 1'b1; uses_rs1_o = 1'b1;
      end
      OPC_STORE: begin
        imm_o = w_imm_s; ctrl_o.memwrite = 1'b1;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
      end
      OPC_OPIMM: begin
        imm_o = w_imm_i; ctrl_o.regwrite = 1'b1; uses_rs1_o = 1'b1;
        case (w_f3)
          F3_SLT:  ctrl_o.alucode = ALU_SLT;
          F3_SLTU: ctrl_o.alucode = ALU_SLTU;
          F3_XOR:  ctrl_o.alucode = ALU_XOR;
          F3_OR:   ctrl_o.alucode = ALU_OR;
          F3_AND:  ctrl_o.alucode = ALU_AND;
          F3_SLL: begin
            imm_o = w_imm_sh; ctrl_o.alucode = ALU_SLL;
            ctrl_o.illegal = !w_shf_base;
          end
          F3_SR: begin
            imm_o = w_imm_sh;
            if (w_shf_base)     ctrl_o.alucode = ALU_SRL;
            else if (w_shf_alt) ctrl_o.alucode = ALU_SRA;
            else                ctrl_o.illegal = 1'b1;
          end
          default: ctrl_o.alucode = ALU_ADD;
        endcase
      end
      OPC_OP: begin
        ctrl_o.alusrcb = 2'd0; ctrl_o.regwrite = 1'b1;
        uses_rs1_o = 1'b1; uses_rs2_o = 1'b1;
        if (w_f7 == F7_BASE) begin
          case (w_f3)
            F3_SLL:  ctrl_o.alucode = ALU_SLL;
            F3_SLT:  ctrl_o.alucode = ALU_SLT;
            F3_SLTU: ctrl_o.alucode = ALU_SLTU;
            F3_XOR:  ctrl_o.alucode = ALU_XOR;
            F3_SR:   ctrl_o.alucode = ALU_SRL;
            F3_OR:   ctrl_o.alucode = ALU_OR;
            F3_AND:  ctrl_o.alucode = ALU_AND;
            default: ctrl_o.alucode = ALU_ADD;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
          ctrl_o.alucode = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
          ctrl_o.alucode = ALU_SRA;
        end else if (w_f7 == F7_MULDIV && M_EXT != 0) begin
          case (w_f3)
            3'd0:    ctrl_o.alucode = ALU_MUL;
            3'd1:    ctrl_o.alucode = ALU_MULH;
            3'd2:    ctrl_o.alucode = ALU_MULHSU;
            3'd3:    ctrl_o.alucode = ALU_MULHU;
            3'd4:    ctrl_o.alucode = ALU_DIV;
            3'd5:    ctrl_o.alucode = ALU_DIVU;
            3'd6:    ctrl_o.alucode = ALU_REM;
            default: ctrl_o.alucode = ALU_REMU;
          endcase
        end else begin
          ctrl_o.illegal = 1'b1;
        end
      end
      default: ctrl_o.illegal = 1'b1;
    endcase
    if (ctrl_o.illegal) begin
      ctrl_o.alucode  = ALU_ADD;
      ctrl_o.regwrite = 1'b0;
      ctrl_o.memread  = 1'b0;
      ctrl_o.memwrite = 1'b0;
      ctrl_o.memtoreg = 1'b0;
      ctrl_o.jump     = 1'b0;
      ctrl_o.jalr     = 1'b0;
      ctrl_o.branch   = 1'b0;
      uses_rs1_o      = 1'b0;
      uses_rs2_o      = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_stage_pipe                                                            |
// | ID stage: decode, ID/EX register, valid/ready handshake, load-use       |
// | hazard bubble insertion, flush and bubble performance counter.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_stage_pipe
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int M_EXT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_alucode,
  output logic            out_alusrca,
  output logic [1:0]      out_alusrcb,
  output logic [2:0]      out_funct3,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_memtoreg,
  output logic            out_jump,
  output logic            out_jalr,
  output logic            out_branch,
  output logic            out_illegal,
  output logic [31:0]     perf_stalls
);

  ctrl_t           w_dec_ctrl;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_uses_rs1, w_uses_rs2;
  logic            w_hazard, w_load, w_bubble;

  ctrl_t           ctrl_q, ctrl_d;
  logic [XLEN-1:0] imm_q, imm_d, pc_q, pc_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     perf_stalls_q, perf_stalls_d;

  decode_core #(.XLEN(XLEN), .M_EXT(M_EXT)) u_decode (
    .instr_i    (in_instr),
    .imm_o      (w_dec_imm),
    .ctrl_o     (w_dec_ctrl),
    .uses_rs1_o (w_uses_rs1),
    .uses_rs2_o (w_uses_rs2)
  );

  // Load in EX slot whose destination feeds the incoming instruction
  assign w_hazard = out_valid_q && ctrl_q.memread && (ctrl_q.rd != 5'd0) && in_valid &&
                    (((ctrl_q.rd == w_dec_ctrl.rs1) && w_uses_rs1) ||
                     ((ctrl_q.rd == w_dec_ctrl.rs2) && w_uses_rs2));
  assign in_ready = !reset && (!out_valid_q || out_ready) && !w_hazard && !flush;
  assign w_load   = in_valid && in_ready;
  assign w_bubble = w_hazard && out_ready && !flush;

  // Next-state for the ID/EX register and the bubble counter
  always_comb begin
    out_valid_d   = out_valid_q;
    ctrl_d        = ctrl_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    perf_stalls_d = perf_stalls_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (w_load) begin
      out_valid_d = 1'b1;
      ctrl_d      = w_dec_ctrl;
      imm_d       = w_dec_imm;
      pc_d        = in_pc;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_bubble && (perf_stalls_q != 32'hFFFF_FFFF)) begin
      perf_stalls_d = perf_stalls_q + 32'd1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      ctrl_q        <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      perf_stalls_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      ctrl_q        <= ctrl_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      perf_stalls_q <= perf_stalls_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_rs1      = ctrl_q.rs1;
  assign out_rs2      = ctrl_q.rs2;
  assign out_rd       = ctrl_q.rd;
  assign out_alucode  = ctrl_q.alucode;
  assign out_alusrca  = ctrl_q.alusrca;
  assign out_alusrcb  = ctrl_q.alusrcb;
  assign out_funct3   = ctrl_q.funct3;
  assign out_regwrite = ctrl_q.regwrite;
  assign out_memread  = ctrl_q.memread;
  assign out_memwrite = ctrl_q.memwrite;
  assign out_memtoreg = ctrl_q.memtoreg;
  assign out_jump     = ctrl_q.jump;
  assign out_jalr     = ctrl_q.jalr;
  assign out_branch   = ctrl_q.branch;
  assign out_illegal  = ctrl_q.illegal;
  assign perf_stalls  = perf_stalls_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_stage_pipe                                                         |
// | Directed bench: RV32 base instance (M off) and RV64 instance (M on),    |
// | both fed the same instruction stream.                                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'd0, in_pc};

  logic        a_in_ready, a_out_valid, a_alusrca, a_regwrite, a_memread, a_memwrite;
  logic        a_memtoreg, a_jump, a_jalr, a_branch, a_illegal;
  logic [31:0] a_out_pc, a_out_imm, a_perf;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_alucode;
  logic [1:0]  a_alusrcb;
  logic [2:0]  a_funct3;

  logic        b_in_ready, b_out_valid, b_alusrca, b_regwrite, b_memread, b_memwrite;
  logic        b_memtoreg, b_jump, b_jalr, b_branch, b_illegal;
  logic [63:0] b_out_pc, b_out_imm;
  logic [31:0] b_perf;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_alucode;
  logic [1:0]  b_alusrcb;
  logic [2:0]  b_funct3;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .M_EXT(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_out_pc), .out_imm(a_out_imm), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_rd(a_rd), .out_alucode(a_alucode), .out_alusrca(a_alusrca),
    .out_alusrcb(a_alusrcb), .out_funct3(a_funct3), .out_regwrite(a_regwrite),
    .out_memread(a_memread), .out_memwrite(a_memwrite), .out_memtoreg(a_memtoreg),
    .out_jump(a_jump), .out_jalr(a_jalr), .out_branch(a_branch),
    .out_illegal(a_illegal), .perf_stalls(a_perf)
  );

  id_stage_pipe #(.XLEN(64), .M_EXT(1)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_rs1(b_rs1),
    .out_rs2(b_rs2), .out_rd(b_rd), .out_alucode(b_alucode), .out_alusrca(b_alusrca),
    .out_alusrcb(b_alusrcb), .out_funct3(b_funct3), .out_regwrite(b_regwrite),
    .out_memread(b_memread), .out_memwrite(b_memwrite), .out_memtoreg(b_memtoreg),
    .out_jump(b_jump), .out_jalr(b_jalr), .out_branch(b_branch),
    .out_illegal(b_illegal), .perf_stalls(b_perf)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd, alu;
    logic        srca;
    logic [1:0]  srcb;
    logic [7:0]  flags;  // {regwrite,memread,memwrite,memtoreg,jump,jalr,branch,illegal}
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];
  int nvec = 0;
  int nerr = 0;

  logic [7:0] a_flags;
  assign a_flags = {a_regwrite, a_memread, a_memwrite, a_memtoreg,
                    a_jump, a_jalr, a_branch, a_illegal};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vt[0]  = '{32'hFFB00093, 32'hFFFFFFFB, 5'd0, 5'd27, 5'd1,  5'd0,  1'b0, 2'd1, 8'h80}; // addi x1,x0,-5
    vt[1]  = '{32'h123452B7, 32'h12345000, 5'd8, 5'd3,  5'd5,  5'd2,  1'b0, 2'd1, 8'h80}; // lui
    vt[2]  = '{32'hFFFFF397, 32'hFFFFF000, 5'd31, 5'd31, 5'd7, 5'd0,  1'b1, 2'd1, 8'h80}; // auipc
    vt[3]  = '{32'hFE312E23, 32'hFFFFFFFC, 5'd2, 5'd3,  5'd28, 5'd0,  1'b0, 2'd1, 8'h20}; // sw x3,-4(x2)
    vt[4]  = '{32'hFE208CE3, 32'hFFFFFFF8, 5'd1, 5'd2,  5'd25, 5'd1,  1'b0, 2'd0, 8'h02}; // beq -8
    vt[5]  = '{32'h010000EF, 32'h00000010, 5'd0, 5'd16, 5'd1,  5'd0,  1'b1, 2'd2, 8'h88}; // jal +16
    vt[6]  = '{32'h00008067, 32'h00000000, 5'd1, 5'd0,  5'd0,  5'd0,  1'b1, 2'd2, 8'h8C}; // jalr
    vt[7]  = '{32'h00012283, 32'h00000000, 5'd2, 5'd0,  5'd5,  5'd0,  1'b0, 2'd1, 8'hD0}; // lw x5
    vt[8]  = '{32'h406201B3, 32'h00000000, 5'd4, 5'd6,  5'd3,  5'd1,  1'b0, 2'd0, 8'h80}; // sub
    vt[9]  = '{32'h4030D093, 32'h00000003, 5'd1, 5'd3,  5'd1,  5'd8,  1'b0, 2'd1, 8'h80}; // srai 3
    vt[10] = '{32'h4020C1B3, 32'h00000000, 5'd1, 5'd2,  5'd3,  5'd0,  1'b0, 2'd0, 8'h01}; // bad f7 xor
    vt[11] = '{32'h023100B3, 32'h00000000, 5'd2, 5'd3,  5'd1,  5'd0,  1'b0, 2'd0, 8'h01}; // mul, M off
    vt[12] = '{32'h0000007F, 32'h00000000, 5'd0, 5'd0,  5'd0,  5'd0,  1'b0, 2'd1, 8'h01}; // bad opcode
    vt[13] = '{32'h40001093, 32'h00000000, 5'd0, 5'd0,  5'd1,  5'd0,  1'b0, 2'd1, 8'h01}; // bad slli
    vt[14] = '{32'h7FF0C113, 32'h000007FF, 5'd1, 5'd31, 5'd2,  5'd4,  1'b0, 2'd1, 8'h80}; // xori

    // Reset with live inputs: no acceptance, everything cleared
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'hFFB00093; in_pc = 32'h0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("rst_in_ready", {63'd0, a_in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_perf", {32'd0, a_perf}, 64'd0);
    chk("rst_imm", {32'd0, a_out_imm}, 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);

    // Back-to-back decode vectors, one per cycle
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_instr = vt[i].instr; in_pc = 32'h1000 + 32'(4 * i);
      tick();
      chk($sformatf("vec%0d", i),
          {a_out_valid, a_out_imm, a_rs1, a_rs2, a_rd, a_alucode, a_alusrca, a_alusrcb, a_flags},
          {1'b1, vt[i].imm, vt[i].rs1, vt[i].rs2, vt[i].rd, vt[i].alu, vt[i].srca, vt[i].srcb, vt[i].flags});
      chk($sformatf("pc%0d", i), {32'd0, a_out_pc}, {32'd0, 32'h1000 + 32'(4 * i)});
    end

    // RV64 / M-extension specifics, cross-checked against the RV32 instance
    in_instr = 32'h43F0D093;  // srai x1,x1,63
    tick();
    chk("b_srai63_imm", b_out_imm, 64'd63);
    chk("b_srai63_alu", {59'd0, b_alucode}, 64'd8);
    chk("b_srai63_ill", {63'd0, b_illegal}, 64'd0);
    chk("a_srai63_ill", {63'd0, a_illegal}, 64'd1);
    in_instr = 32'h801FF0EF;  // jal x1,-2048
    tick();
    chk("b_jal_imm", b_out_imm, 64'hFFFFFFFFFFFFF800);
    chk("a_jal_imm", {32'd0, a_out_imm}, {32'd0, 32'hFFFFF800});
    in_instr = 32'h023100B3;  // mul x1,x2,x3
    tick();
    chk("b_mul", {57'd0, b_alucode, b_regwrite, b_illegal}, {57'd0, 5'd11, 1'b1, 1'b0});
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {63'd0, a_out_valid}, 64'd0);

    // Load-use: lw x5 then add x6,x5,x3
    in_valid = 1'b1; in_instr = 32'h00012283;
    tick();
    in_instr = 32'h00328333;
    #1;
    chk("lu_in_ready", {63'd0, a_in_ready}, 64'd0);
    tick();
    chk("lu_bubble", {31'd0, a_out_valid, a_perf}, {31'd0, 1'b0, 32'd1});
    tick();
    chk("lu_add", {57'd0, a_out_valid, a_rd, a_memread}, {57'd0, 1'b1, 5'd6, 1'b0});
    in_valid = 1'b0;
    tick();

    // Held hazard with out_ready low: output frozen, nothing counted
    in_valid = 1'b1; in_instr = 32'h00012283;
    tick();
    out_ready = 1'b0; in_instr = 32'h00328333;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("hold_rdy%0d", c), {63'd0, a_in_ready}, 64'd0);
      tick();
      chk($sformatf("hold_out%0d", c),
          {a_out_valid, a_rd, a_memread, a_out_imm, a_perf[24:0]},
          {1'b1, 5'd5, 1'b1, 32'd0, 25'd1});
    end

    // Flush with pending input and hazard: stage empties, input dropped
    flush = 1'b1;
    tick();
    chk("flush_valid", {63'd0, a_out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush_drop", {31'd0, a_out_valid, a_perf}, {31'd0, 1'b0, 32'd1});

    // Reset in the middle of a stall
    in_valid = 1'b1; in_instr = 32'h00012283;
    tick();
    out_ready = 1'b0; in_instr = 32'h00328333;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid_rst", {30'd0, a_in_ready, a_out_valid, a_perf}, {30'd0, 1'b1, 1'b0, 32'd0});
    tick();
    chk("mid_rst_accept", {58'd0, a_out_valid, a_rd}, {58'd0, 1'b1, 5'd6});
    in_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter M_EXT, default 0, 1 enables RV-M decode.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; reset  in  1  reset.
REQ-004 Ports SHALL be: in_valid  in  1  IF/ID entry valid; in_ready  out  1  stage accepts entry.
REQ-005 Ports SHALL be: in_instr  in  32  instruction; in_pc  in  XLEN  instruction PC.
REQ-006 Ports SHALL be: flush  in  1  kill stage contents (taken branch/jump).
REQ-007 Ports SHALL be: out_valid  out  1  ID/EX entry valid; out_ready  in  1  EX accepts entry.
REQ-008 Ports SHALL be: out_pc  out  XLEN  PC; out_imm  out  XLEN  immediate/offset; out_rs1, out_rs2, out_rd  out  5 each  register indices.
REQ-009 Ports SHALL be: out_alucode  out  5  ALU op; out_alusrca  out  1; out_alusrcb  out  2; out_funct3  out  3.
REQ-010 Ports SHALL be: out_regwrite, out_memread, out_memwrite, out_memtoreg, out_jump, out_jalr, out_branch, out_illegal  out  1 each.
REQ-011 Ports SHALL be: perf_stalls  out  32  load-use bubble count.

Function
REQ-012 Decoding SHALL cover LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP (plus RV-M when M_EXT=1).
REQ-013 ALU codes SHALL be add 0, sub 1, lui 2, and 3, xor 4, or 5, sll 6, srl 7, sra 8, slt 9, sltu 10; M_EXT adds mul 11, mulh 12, mulhsu 13, mulhu 14, div 15, divu 16, rem 17, remu 18.
REQ-014 Immediates SHALL be sign-extended to XLEN (I, S, B, U, J formats); B/J carry bit0=0; shift-immediates zero-extended with shamt width 5 (XLEN=32) or 6 (XLEN=64).
REQ-015 Immediate and branch/jump offsets SHALL share out_imm; no output held from a prior instruction (no latch behaviour).
REQ-016 alusrca SHALL be 1 for JAL/JALR/AUIPC; alusrcb = 2 for JAL/JALR, 0 for OP/BRANCH, else 1.
REQ-017 Unknown opcode, OP funct7 not in {0000000, 0100000 (add/srl only), 0000001 (M_EXT=1 only)}, or slli/srli/srai with illegal funct7 SHALL set out_illegal=1, force regwrite/memwrite/memread/jump/branch=0, alucode=0.
REQ-018 The ID/EX register SHALL load decoded fields on in_valid && in_ready; latency in→out is exactly one cycle.
REQ-019 in_ready SHALL equal (!out_valid || out_ready) && !hazard && !flush.
REQ-020 hazard SHALL be out_valid && out_memread && out_rd!=0 && in_valid && ((out_rd==rs1 && uses_rs1) || (out_rd==rs2 && uses_rs2)).
REQ-021 On hazard with out_ready=1 the stage SHALL drain the load and present out_valid=0 next cycle (one bubble), then accept the dependent instruction.
REQ-022 On hazard with out_ready=0 the output register SHALL hold unchanged; no bubble counted.
REQ-023 perf_stalls SHALL increment once per inserted bubble and saturate at 0xFFFFFFFF.
REQ-024 flush SHALL clear out_valid next cycle, override a simultaneous load or hazard, and drop the input entry.
REQ-025 When out_valid=1 and out_ready=0, all out_* SHALL remain stable.

Reset
REQ-026 Reset SHALL clear out_valid, all out_* fields and perf_stalls to 0; in_ready SHALL be 0 during reset.
REQ-027 Reset mid-stall SHALL discard held entry and bubble state; first cycle after reset in_ready=1.

Structure
REQ-028 Opcodes, funct3/funct7 constants and ALU codes SHALL live in shared package cpu_pkg.
REQ-029 Combinational decode SHALL be sub-module decode_core (XLEN, M_EXT parameters); id_stage_pipe holds register, handshake, hazard, counter.

Verification
REQ-030 addi x1,x0,-5 (0xFFB00093), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFB, alucode=0, regwrite=1.
REQ-031 lw x5,0(x2) then add x6,x5,x3 back-to-back -> one bubble, add issued second cycle after lw, perf_stalls=1.
REQ-032 out_ready=0 for 3 cycles with valid entry -> outputs stable, in_ready=0, no count.
REQ-033 mul x1,x2,x3 (0x023100B3): M_EXT=1 -> alucode=11; M_EXT=0 -> out_illegal=1, regwrite=0.
REQ-034 flush asserted with in_valid and pending hazard -> out_valid=0 next cycle, input dropped.
REQ-035 XLEN=64 srai x1,x1,63 -> out_imm=63, alucode=8; jal offset -2048 -> out_imm=0xFFFFFFFFFFFFF800.
